// File: rtl/axi_write_master.sv
// AXI4 write-channel master: queues user write commands, issues AW bursts,
// sequences W beats with WLAST per burst and tracks outstanding B responses.
// Ports:
//   clk, resetn                    clock / asynchronous active-low reset
//   awaddr/len/size/burst/valid_in  user command; awready_out = command FIFO not full
//   wdata_in, wstrb_in, wvalid_in   user write data; wready_out = axi_wready in data phase
//   axi_aw*                         AW channel (payload and valid registered)
//   axi_w*                          W channel (data/strobe pass through, wlast per burst)
//   axi_b*, bready_in               B channel pass-through to/from the user
//   outstanding                     bursts with AW done and B pending
//   err_sticky                      dropped illegal command or error/unexpected response
module axi_write_master #(
    parameter int unsigned AW              = 32,
    parameter int unsigned DW              = 64,
    parameter int unsigned CMD_DEPTH       = 4,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic [AW-1:0]                        awaddr_in,
    input  logic [7:0]                           awlen_in,
    input  logic [2:0]                           awsize_in,
    input  logic [1:0]                           awburst_in,
    input  logic                                 awvalid_in,
    output logic                                 awready_out,
    input  logic [DW-1:0]                        wdata_in,
    input  logic [DW/8-1:0]                      wstrb_in,
    input  logic                                 wvalid_in,
    output logic                                 wready_out,
    output logic [AW-1:0]                        axi_awaddr,
    output logic [7:0]                           axi_awlen,
    output logic [2:0]                           axi_awsize,
    output logic [1:0]                           axi_awburst,
    output logic                                 axi_awvalid,
    input  logic                                 axi_awready,
    output logic [DW-1:0]                        axi_wdata,
    output logic [DW/8-1:0]                      axi_wstrb,
    output logic                                 axi_wlast,
    output logic                                 axi_wvalid,
    input  logic                                 axi_wready,
    input  logic [1:0]                           axi_bresp,
    input  logic                                 axi_bvalid,
    output logic                                 axi_bready,
    input  logic                                 bready_in,
    output logic                                 bvalid_out,
    output logic [1:0]                           bresp_out,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 err_sticky
);

    localparam int unsigned SW       = DW / 8;
    localparam int unsigned MAX_SIZE = $clog2(SW);
    localparam int unsigned CPW      = $clog2(CMD_DEPTH);
    localparam int unsigned CCW      = $clog2(CMD_DEPTH + 1);
    localparam int unsigned BPW      = $clog2(MAX_OUTSTANDING);
    localparam int unsigned OW       = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
    } cmd_t;

    typedef enum logic { AW_IDLE, AW_ISSUE } aw_state_t;
    typedef enum logic { W_IDLE,  W_DATA   } w_state_t;

    aw_state_t      aw_state;
    w_state_t       w_state;

    cmd_t           cmd_mem [CMD_DEPTH];
    logic [CPW-1:0] cmd_wr_ptr, cmd_rd_ptr;
    logic [CCW-1:0] cmd_count, cmd_count_next;

    // Beat queue: awlen of each burst whose AW is done and whose W is not yet complete
    logic [7:0]     bq_mem [MAX_OUTSTANDING];
    logic [BPW-1:0] bq_wr_ptr, bq_rd_ptr;
    logic [OW-1:0]  bq_count, bq_count_next;
    logic [7:0]     beat_cnt;

    logic [OW-1:0]  out_next;
    cmd_t           cmd_in, cmd_head, cmd_after_head;
    logic           cmd_legal, cmd_hs, cmd_push;
    logic           aw_hs, w_hs, w_last_hs, b_hs, b_counted;
    logic           issue_ok_idle, issue_ok_next;

    // Command legality: size within bus width, no reserved burst, WRAP length 2/4/8/16
    assign cmd_legal = (32'(awsize_in) <= MAX_SIZE) && (awburst_in != 2'b11) &&
                       !((awburst_in == 2'b10) &&
                         !((awlen_in == 8'd1) || (awlen_in == 8'd3) ||
                           (awlen_in == 8'd7) || (awlen_in == 8'd15)));

    assign cmd_in = '{addr: awaddr_in, len: awlen_in, size: awsize_in, burst: awburst_in};

    assign awready_out = (32'(cmd_count) < CMD_DEPTH);
    assign cmd_hs      = awvalid_in & awready_out;
    assign cmd_push    = cmd_hs & cmd_legal;
    assign aw_hs       = axi_awvalid & axi_awready;
    assign w_hs        = axi_wvalid & axi_wready;
    assign w_last_hs   = w_hs & axi_wlast;
    assign b_hs        = axi_bvalid & axi_bready;
    // A response with nothing outstanding is flagged but never underflows the counter
    assign b_counted   = b_hs && (outstanding != '0);

    assign cmd_count_next = cmd_count + CCW'(cmd_push) - CCW'(aw_hs);
    assign bq_count_next  = bq_count + OW'(aw_hs) - OW'(w_last_hs);
    assign out_next       = outstanding + OW'(aw_hs) - OW'(b_counted);

    assign cmd_head       = cmd_mem[cmd_rd_ptr];
    assign cmd_after_head = cmd_mem[cmd_rd_ptr + CPW'(1)];

    assign issue_ok_idle = (cmd_count != '0) &&
                           (32'(outstanding) < MAX_OUTSTANDING) &&
                           (32'(bq_count) < MAX_OUTSTANDING);
    // Back-to-back issue uses the entry behind the head being popped this cycle
    assign issue_ok_next = (cmd_count > CCW'(1)) &&
                           (32'(out_next) < MAX_OUTSTANDING) &&
                           (32'(bq_count_next) < MAX_OUTSTANDING);

    // W channel and B channel pass-through
    assign axi_wdata  = wdata_in;
    assign axi_wstrb  = wstrb_in;
    assign axi_wvalid = wvalid_in & (w_state == W_DATA);
    assign wready_out = axi_wready & (w_state == W_DATA);
    assign axi_wlast  = (w_state == W_DATA) && (beat_cnt == bq_mem[bq_rd_ptr]);
    assign axi_bready = bready_in;
    assign bvalid_out = axi_bvalid;
    assign bresp_out  = axi_bresp;

    // Queue storage, no reset needed: occupancy is tracked by the counters
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wr_ptr] <= cmd_in;
        end
        if (aw_hs) begin
            bq_mem[bq_wr_ptr] <= axi_awlen;
        end
    end

    // Control state: queue pointers, AW and W FSMs, outstanding counter, error flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_state    <= AW_IDLE;
            w_state     <= W_IDLE;
            cmd_wr_ptr  <= '0;
            cmd_rd_ptr  <= '0;
            cmd_count   <= '0;
            bq_wr_ptr   <= '0;
            bq_rd_ptr   <= '0;
            bq_count    <= '0;
            beat_cnt    <= '0;
            outstanding <= '0;
            err_sticky  <= 1'b0;
            axi_awaddr  <= '0;
            axi_awlen   <= '0;
            axi_awsize  <= '0;
            axi_awburst <= '0;
            axi_awvalid <= 1'b0;
        end else begin
            if (cmd_push) begin
                cmd_wr_ptr <= cmd_wr_ptr + CPW'(1);
            end
            if (aw_hs) begin
                cmd_rd_ptr <= cmd_rd_ptr + CPW'(1);
                bq_wr_ptr  <= bq_wr_ptr + BPW'(1);
            end
            if (w_last_hs) begin
                bq_rd_ptr <= bq_rd_ptr + BPW'(1);
            end
            cmd_count   <= cmd_count_next;
            bq_count    <= bq_count_next;
            outstanding <= out_next;

            if ((cmd_hs && !cmd_legal) ||
                (b_hs && (axi_bresp[1] || (outstanding == '0)))) begin
                err_sticky <= 1'b1;
            end

            case (aw_state)
                AW_IDLE: begin
                    if (issue_ok_idle) begin
                        axi_awaddr  <= cmd_head.addr;
                        axi_awlen   <= cmd_head.len;
                        axi_awsize  <= cmd_head.size;
                        axi_awburst <= cmd_head.burst;
                        axi_awvalid <= 1'b1;
                        aw_state    <= AW_ISSUE;
                    end
                end
                AW_ISSUE: begin
                    if (axi_awready) begin
                        if (issue_ok_next) begin
                            axi_awaddr  <= cmd_after_head.addr;
                            axi_awlen   <= cmd_after_head.len;
                            axi_awsize  <= cmd_after_head.size;
                            axi_awburst <= cmd_after_head.burst;
                        end else begin
                            axi_awvalid <= 1'b0;
                            aw_state    <= AW_IDLE;
                        end
                    end
                end
                default: begin
                    axi_awvalid <= 1'b0;
                    aw_state    <= AW_IDLE;
                end
            endcase

            case (w_state)
                W_IDLE: begin
                    if (bq_count != '0) begin
                        beat_cnt <= '0;
                        w_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (axi_wlast) begin
                            beat_cnt <= '0;
                            if (bq_count_next == '0) begin
                                w_state <= W_IDLE;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_master.sv
// Self-checking bench for axi_write_master: directed scenarios plus a randomized
// run scored against a queue-based model of commands, bursts and responses.
module tb_axi_write_master;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] awaddr_in;
    logic [7:0]  awlen_in;
    logic [2:0]  awsize_in;
    logic [1:0]  awburst_in;
    logic        awvalid_in;
    logic        awready_out;
    logic [63:0] wdata_in;
    logic [7:0]  wstrb_in;
    logic        wvalid_in;
    logic        wready_out;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [63:0] axi_wdata;
    logic [7:0]  axi_wstrb;
    logic        axi_wlast;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic        bready_in;
    logic        bvalid_out;
    logic [1:0]  bresp_out;
    logic [3:0]  outstanding;
    logic        err_sticky;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  l;
        logic [2:0]  s;
        logic [1:0]  b;
    } cmd_s;

    axi_write_master #(.AW(32), .DW(64), .CMD_DEPTH(4), .MAX_OUTSTANDING(8)) dut (
        .clk(clk), .resetn(resetn),
        .awaddr_in(awaddr_in), .awlen_in(awlen_in), .awsize_in(awsize_in),
        .awburst_in(awburst_in), .awvalid_in(awvalid_in), .awready_out(awready_out),
        .wdata_in(wdata_in), .wstrb_in(wstrb_in), .wvalid_in(wvalid_in), .wready_out(wready_out),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .bready_in(bready_in), .bvalid_out(bvalid_out), .bresp_out(bresp_out),
        .outstanding(outstanding), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Legality rules for a 64-bit bus
    function automatic bit legal(input cmd_s c);
        return (c.s <= 3'd3) && (c.b != 2'b11) &&
               !((c.b == 2'b10) && !(c.l inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_idle();
        awaddr_in = '0; awlen_in = '0; awsize_in = '0; awburst_in = 2'b01; awvalid_in = 1'b0;
        wdata_in = '0; wstrb_in = '0; wvalid_in = 1'b0;
        axi_awready = 1'b0; axi_wready = 1'b0;
        axi_bresp = 2'b00; axi_bvalid = 1'b0; bready_in = 1'b1;
    endtask

    task automatic do_reset();
        set_idle();
        resetn = 1'b0;
        repeat (2) step();
        resetn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        set_idle();
        resetn = 1'b0;
        awvalid_in = 1'b1; awaddr_in = 32'hDEAD_BEE0; awlen_in = 8'd3; awsize_in = 3'd3;
        wvalid_in = 1'b1; axi_awready = 1'b1; axi_wready = 1'b1;
        sample(); sample();
        checks++; if (axi_awvalid !== 1'b0) begin errors++; $display("FAIL reset_awvalid: got %b expected 0", axi_awvalid); end
        checks++; if (axi_wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid: got %b expected 0", axi_wvalid); end
        checks++; if (wready_out !== 1'b0) begin errors++; $display("FAIL reset_wready: got %b expected 0", wready_out); end
        checks++; if (axi_wlast !== 1'b0) begin errors++; $display("FAIL reset_wlast: got %b expected 0", axi_wlast); end
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_sticky); end
        checks++; if (axi_awaddr !== 32'h0) begin errors++; $display("FAIL reset_awaddr: got %h expected 0", axi_awaddr); end
        checks++; if (axi_awlen !== 8'h0) begin errors++; $display("FAIL reset_awlen: got %h expected 0", axi_awlen); end
        checks++; if (awready_out !== 1'b1) begin errors++; $display("FAIL reset_awready: got %b expected 1", awready_out); end
        step();
        set_idle();
        resetn = 1'b1;
        step();
    endtask

    // Single INCR burst: AW two cycles after acceptance, four beats, wlast on the fourth
    task automatic test_incr();
        int beats = 0;
        set_idle();
        axi_awready = 1'b1; axi_wready = 1'b1;
        step();
        awaddr_in = 32'h1000; awlen_in = 8'd3; awsize_in = 3'd3; awburst_in = 2'b01; awvalid_in = 1'b1;
        sample();
        checks++; if (awready_out !== 1'b1) begin errors++; $display("FAIL incr_awready: got %b expected 1", awready_out); end
        step(); awvalid_in = 1'b0;
        sample();
        checks++; if (axi_awvalid !== 1'b0) begin errors++; $display("FAIL incr_awvalid_n1: got %b expected 0", axi_awvalid); end
        step(); sample();
        checks++; if (axi_awvalid !== 1'b1) begin errors++; $display("FAIL incr_awvalid_n2: got %b expected 1", axi_awvalid); end
        checks++; if ({axi_awaddr, axi_awlen, axi_awsize, axi_awburst} !== {32'h1000, 8'd3, 3'd3, 2'b01}) begin
            errors++; $display("FAIL incr_aw_payload: got %h/%0d/%0d/%0d expected 1000/3/3/1", axi_awaddr, axi_awlen, axi_awsize, axi_awburst);
        end
        step(); wvalid_in = 1'b1;
        sample();
        checks++; if (axi_awvalid !== 1'b0) begin errors++; $display("FAIL incr_awvalid_n3: got %b expected 0", axi_awvalid); end
        checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL incr_outstanding1: got %0d expected 1", outstanding); end
        checks++; if (axi_wvalid !== 1'b0) begin errors++; $display("FAIL incr_wvalid_early: got %b expected 0", axi_wvalid); end
        for (int i = 0; i < 12 && beats < 4; i++) begin
            step();
            wdata_in = {$urandom, $urandom}; wstrb_in = 8'($urandom);
            sample();
            if (axi_wvalid && axi_wready) begin
                beats++;
                checks++; if (axi_wlast !== (beats == 4)) begin errors++; $display("FAIL incr_wlast: beat %0d got %b expected %b", beats, axi_wlast, beats == 4); end
                checks++; if ({axi_wdata, axi_wstrb} !== {wdata_in, wstrb_in}) begin errors++; $display("FAIL incr_wdata: got %h expected %h", axi_wdata, wdata_in); end
            end
        end
        step(); wvalid_in = 1'b0;
        checks++; if (beats !== 4) begin errors++; $display("FAIL incr_beats: got %0d expected 4", beats); end
        axi_bvalid = 1'b1; axi_bresp = 2'b00;
        sample();
        checks++; if (bvalid_out !== 1'b1 || axi_bready !== 1'b1) begin errors++; $display("FAIL incr_b_passthru: got %b%b expected 11", bvalid_out, axi_bready); end
        step(); axi_bvalid = 1'b0;
        sample();
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL incr_outstanding0: got %0d expected 0", outstanding); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL incr_err: got %b expected 0", err_sticky); end
    endtask

    // Commands len 0 then len 1 on consecutive cycles: AW on consecutive cycles, wlast on beats 1 and 3
    task automatic test_back_to_back();
        int beats = 0;
        set_idle();
        axi_awready = 1'b1; axi_wready = 1'b1; wvalid_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            awvalid_in = (i < 2);
            awlen_in = (i == 0) ? 8'd0 : 8'd1;
            awaddr_in = 32'h2000 + 32'(i) * 32'h40;
            awsize_in = 3'd2;
            wdata_in = {$urandom, $urandom};
            sample();
            if (i == 2 || i == 3) begin
                checks++; if (axi_awvalid !== 1'b1 || axi_awlen !== 8'(i - 2)) begin
                    errors++; $display("FAIL b2b_aw_c%0d: got valid %b len %0d expected valid 1 len %0d", i, axi_awvalid, axi_awlen, i - 2);
                end
            end else if (i == 4) begin
                checks++; if (axi_awvalid !== 1'b0) begin errors++; $display("FAIL b2b_aw_end: got %b expected 0", axi_awvalid); end
            end
            if (axi_wvalid && axi_wready) begin
                beats++;
                checks++; if (axi_wlast !== (beats == 1 || beats == 3)) begin
                    errors++; $display("FAIL b2b_wlast: beat %0d got %b expected %b", beats, axi_wlast, beats == 1 || beats == 3);
                end
            end
        end
        checks++; if (beats !== 3) begin errors++; $display("FAIL b2b_beats: got %0d expected 3", beats); end
        step(); wvalid_in = 1'b0; axi_bvalid = 1'b1;
        step(); step(); axi_bvalid = 1'b0;
        sample();
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL b2b_outstanding: got %0d expected 0", outstanding); end
    endtask

    // No responses: outstanding saturates at 8 and the ninth AW waits for a B
    task automatic test_saturation();
        int sent = 0;
        int aw = 0;
        bit seen = 0;
        set_idle();
        axi_awready = 1'b1; axi_wready = 1'b1; wvalid_in = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            awvalid_in = (sent < 9); awlen_in = 8'd0; awsize_in = 3'd3;
            awaddr_in = 32'h3000 + 32'(sent) * 32'h8;
            sample();
            checks++; if (outstanding !== 4'(aw)) begin errors++; $display("FAIL sat_track: got %0d expected %0d", outstanding, aw); end
            if (awvalid_in && awready_out) sent++;
            if (axi_awvalid && axi_awready) aw++;
        end
        checks++; if (aw !== 8) begin errors++; $display("FAIL sat_aw_count: got %0d expected 8", aw); end
        checks++; if (sent !== 9) begin errors++; $display("FAIL sat_sent: got %0d expected 9", sent); end
        checks++; if (axi_awvalid !== 1'b0) begin errors++; $display("FAIL sat_stall: got %b expected 0", axi_awvalid); end
        checks++; if (outstanding !== 4'd8) begin errors++; $display("FAIL sat_full: got %0d expected 8", outstanding); end
        step(); awvalid_in = 1'b0; axi_bvalid = 1'b1;
        step(); axi_bvalid = 1'b0;
        sample();
        checks++; if (outstanding !== 4'd7) begin errors++; $display("FAIL sat_after_b: got %0d expected 7", outstanding); end
        for (int i = 0; i < 6 && !seen; i++) begin
            step(); sample();
            if (axi_awvalid && axi_awready) seen = 1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL sat_ninth_aw: got %b expected 1", seen); end
        step(); sample();
        checks++; if (outstanding !== 4'd8) begin errors++; $display("FAIL sat_refill: got %0d expected 8", outstanding); end
        step(); axi_bvalid = 1'b1;
        repeat (8) step();
        axi_bvalid = 1'b0; wvalid_in = 1'b0;
        sample();
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL sat_drain: got %0d expected 0", outstanding); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL sat_err: got %b expected 0", err_sticky); end
    endtask

    // WRAP len 2 and size 4 are accepted then dropped with the error flag set
    task automatic test_illegal();
        do_reset();
        axi_awready = 1'b1; axi_wready = 1'b1;
        awvalid_in = 1'b1; awaddr_in = 32'h4000; awlen_in = 8'd2; awsize_in = 3'd3; awburst_in = 2'b10;
        sample();
        checks++; if (awready_out !== 1'b1) begin errors++; $display("FAIL ill_awready: got %b expected 1", awready_out); end
        step();
        awlen_in = 8'd0; awsize_in = 3'd4; awburst_in = 2'b01;
        sample();
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL ill_err_wrap: got %b expected 1", err_sticky); end
        step(); awvalid_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sample();
            checks++; if (axi_awvalid !== 1'b0) begin errors++; $display("FAIL ill_no_aw: cycle %0d got %b expected 0", i, axi_awvalid); end
            step();
        end
        sample();
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL ill_err_hold: got %b expected 1", err_sticky); end
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL ill_outstanding: got %0d expected 0", outstanding); end
    endtask

    // SLVERR on the second of three responses: flag latches, counter walks 3 -> 0
    task automatic test_bresp_error();
        do_reset();
        axi_awready = 1'b1; axi_wready = 1'b1; wvalid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            awvalid_in = 1'b1; awlen_in = 8'd0; awsize_in = 3'd3; awaddr_in = 32'h5000 + 32'(i) * 32'h8;
            step();
        end
        awvalid_in = 1'b0;
        repeat (12) step();
        sample();
        checks++; if (outstanding !== 4'd3) begin errors++; $display("FAIL berr_start: got %0d expected 3", outstanding); end
        for (int k = 0; k < 3; k++) begin
            step(); axi_bvalid = 1'b1; axi_bresp = (k == 1) ? 2'b10 : 2'b00;
            step(); axi_bvalid = 1'b0; axi_bresp = 2'b00;
            sample();
            checks++; if (outstanding !== 4'(2 - k)) begin errors++; $display("FAIL berr_count%0d: got %0d expected %0d", k, outstanding, 2 - k); end
            checks++; if (err_sticky !== (k >= 1)) begin errors++; $display("FAIL berr_flag%0d: got %b expected %b", k, err_sticky, k >= 1); end
        end
    endtask

    // Reset asserted during beat 2 of an 8-beat burst, then a fresh command
    task automatic test_reset_mid_burst();
        int beats = 0;
        bit seen = 0;
        do_reset();
        axi_awready = 1'b1; axi_wready = 1'b1; wvalid_in = 1'b1;
        awvalid_in = 1'b1; awaddr_in = 32'h6000; awlen_in = 8'd7; awsize_in = 3'd3; awburst_in = 2'b01;
        step(); awvalid_in = 1'b0;
        for (int i = 0; i < 12 && beats < 1; i++) begin
            sample();
            if (axi_wvalid && axi_wready) beats++;
            step();
        end
        sample();
        checks++; if (axi_wvalid !== 1'b1 || axi_wlast !== 1'b0) begin errors++; $display("FAIL mrst_beat2: got wvalid %b wlast %b expected 1 0", axi_wvalid, axi_wlast); end
        resetn = 1'b0;
        #1;
        checks++; if ({axi_wvalid, wready_out, axi_wlast, axi_awvalid} !== 4'b0000) begin
            errors++; $display("FAIL mrst_valids: got %b expected 0000", {axi_wvalid, wready_out, axi_wlast, axi_awvalid});
        end
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL mrst_outstanding: got %0d expected 0", outstanding); end
        checks++; if (axi_awaddr !== 32'h0 || axi_awlen !== 8'h0) begin errors++; $display("FAIL mrst_payload: got %h/%0d expected 0/0", axi_awaddr, axi_awlen); end
        step();
        resetn = 1'b1;
        awvalid_in = 1'b1; awaddr_in = 32'h7000; awlen_in = 8'd0; awsize_in = 3'd2; awburst_in = 2'b00;
        step(); awvalid_in = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            sample();
            if (axi_awvalid && axi_awready) begin
                seen = 1;
                checks++; if ({axi_awaddr, axi_awlen, axi_awsize, axi_awburst} !== {32'h7000, 8'd0, 3'd2, 2'b00}) begin
                    errors++; $display("FAIL mrst_new_aw: got %h/%0d/%0d/%0d expected 7000/0/2/0", axi_awaddr, axi_awlen, axi_awsize, axi_awburst);
                end
            end
            step();
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mrst_new_aw_seen: got %b expected 1", seen); end
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            sample();
            if (axi_wvalid && axi_wready) begin
                seen = 1;
                checks++; if (axi_wlast !== 1'b1) begin errors++; $display("FAIL mrst_new_wlast: got %b expected 1", axi_wlast); end
            end
            step();
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mrst_new_w_seen: got %b expected 1", seen); end
        wvalid_in = 1'b0;
        sample();
        checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL mrst_new_outstanding: got %0d expected 1", outstanding); end
    endtask

    // Random traffic scored against queues: FIFO occupancy, AW order, burst beats, responses
    task automatic test_random();
        cmd_s cmds[$];
        cmd_s exp_aw[$];
        int   w_q[$];
        int   idx = 0, beat = 0, b_pend = 0, out_m = 0, fifo_m = 0, cyc;
        bit   err_m = 0;
        cmd_s c;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            c.a = $urandom;
            c.l = 8'($urandom_range(0, 5));
            c.s = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
            c.b = ($urandom_range(0, 11) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if (c.b == 2'b10) c.l = ($urandom_range(0, 4) == 0) ? 8'd2 : 8'(2 ** $urandom_range(1, 3) - 1);
            cmds.push_back(c);
        end
        for (cyc = 0; cyc < 4000; cyc++) begin
            step();
            awvalid_in = (idx < cmds.size()) && ($urandom_range(0, 3) != 0);
            if (idx < cmds.size()) begin
                awaddr_in = cmds[idx].a; awlen_in = cmds[idx].l; awsize_in = cmds[idx].s; awburst_in = cmds[idx].b;
            end
            axi_awready = ($urandom_range(0, 2) != 0);
            axi_wready  = ($urandom_range(0, 2) != 0);
            wvalid_in   = ($urandom_range(0, 3) != 0);
            wdata_in    = {$urandom, $urandom};
            wstrb_in    = 8'($urandom);
            bready_in   = ($urandom_range(0, 3) != 0);
            axi_bvalid  = (b_pend > 0) && ($urandom_range(0, 1) != 0);
            axi_bresp   = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            sample();
            checks++; if (outstanding !== 4'(out_m)) begin errors++; $display("FAIL rnd_outstanding c%0d: got %0d expected %0d", cyc, outstanding, out_m); end
            checks++; if (err_sticky !== err_m) begin errors++; $display("FAIL rnd_err c%0d: got %b expected %b", cyc, err_sticky, err_m); end
            checks++; if (awready_out !== (fifo_m < 4)) begin errors++; $display("FAIL rnd_awready c%0d: got %b expected %b", cyc, awready_out, fifo_m < 4); end
            checks++; if (axi_bready !== bready_in || bvalid_out !== axi_bvalid || bresp_out !== axi_bresp) begin
                errors++; $display("FAIL rnd_b_passthru c%0d: got %b%b%b expected %b%b%b", cyc, axi_bready, bvalid_out, bresp_out, bready_in, axi_bvalid, axi_bresp);
            end
            if (axi_wvalid && axi_wready) begin
                checks++; if ({axi_wdata, axi_wstrb} !== {wdata_in, wstrb_in}) begin errors++; $display("FAIL rnd_wdata c%0d: got %h expected %h", cyc, axi_wdata, wdata_in); end
                if (w_q.size() == 0) begin
                    checks++; errors++; $display("FAIL rnd_w_early c%0d: got a W beat expected none pending", cyc);
                end else begin
                    checks++; if (axi_wlast !== (beat == w_q[0])) begin errors++; $display("FAIL rnd_wlast c%0d: got %b expected %b", cyc, axi_wlast, beat == w_q[0]); end
                    if (beat == w_q[0]) begin
                        void'(w_q.pop_front()); beat = 0; b_pend++;
                    end else begin
                        beat++;
                    end
                end
            end
            if (axi_awvalid && axi_awready) begin
                if (exp_aw.size() == 0) begin
                    checks++; errors++; $display("FAIL rnd_aw_extra c%0d: got AW %h expected none", cyc, axi_awaddr);
                end else begin
                    checks++; if ({axi_awaddr, axi_awlen, axi_awsize, axi_awburst} !== exp_aw[0]) begin
                        errors++; $display("FAIL rnd_aw_payload c%0d: got %h expected %h", cyc, {axi_awaddr, axi_awlen, axi_awsize, axi_awburst}, exp_aw[0]);
                    end
                    w_q.push_back(int'(exp_aw[0].l));
                    void'(exp_aw.pop_front());
                    out_m++; fifo_m--;
                end
            end
            if (axi_bvalid && bready_in) begin
                out_m--; b_pend--;
                if (axi_bresp[1]) err_m = 1;
            end
            if (awvalid_in && awready_out) begin
                if (legal(cmds[idx])) begin
                    exp_aw.push_back(cmds[idx]); fifo_m++;
                end else begin
                    err_m = 1;
                end
                idx++;
            end
            if (idx == cmds.size() && exp_aw.size() == 0 && w_q.size() == 0 && b_pend == 0) break;
        end
        checks++; if (cyc >= 4000) begin errors++; $display("FAIL rnd_timeout: got %0d cycles expected completion, %0d cmds left", cyc, cmds.size() - idx); end
        step(); set_idle();
        sample();
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL rnd_final_outstanding: got %0d expected 0", outstanding); end
    endtask

    initial begin
        set_idle();
        resetn = 1'b0;
        test_reset();
        test_incr();
        test_back_to_back();
        test_saturation();
        test_illegal();
        test_bresp_error();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
